// File: rtl/axi_line_pkg.sv
// Shared types and constants for the AXI cache-line controller: FSM states,
// AXI burst/response encodings and small elaboration-time helpers.
package axi_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_RDATA = 3'd2,
        ST_FILL  = 3'd3,
        ST_AW    = 3'd4,
        ST_WDATA = 3'd5,
        ST_BRESP = 3'd6,
        ST_DONE  = 3'd7
    } line_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         ID_W        = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic e;
        case (resp)
            RESP_OKAY:   e = 1'b0;
            RESP_EXOKAY: e = 1'b0;
            RESP_SLVERR: e = 1'b1;
            RESP_DECERR: e = 1'b1;
            default:     e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/axi_line_ctl_arb.sv
// NPORT requester arbiter. Fixed lowest-index priority by default;
// defining AXI_LINE_CTL_RR_EN rotates the search start after each completion.
module axi_line_arb
    import axi_line_pkg::*;
#(
    parameter  int NPORT = 2,
    localparam int PS_W  = clog2(NPORT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             advance,
    input  logic [PS_W-1:0]  last_gnt,
    output logic [PS_W-1:0]  gnt_idx,
    output logic             gnt_valid
);

`ifdef AXI_LINE_CTL_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [PS_W-1:0] ptr_r;
    logic [PS_W-1:0] base_s;
    logic [PS_W-1:0] cand_s;
    int              sum_s;

    assign base_s = RR_EN ? ptr_r : {PS_W{1'b0}};

    // Search downward so the candidate closest to the pointer overwrites the rest.
    always_comb begin
        gnt_idx   = {PS_W{1'b0}};
        gnt_valid = 1'b0;
        sum_s     = 0;
        cand_s    = {PS_W{1'b0}};
        for (int i = NPORT - 1; i >= 0; i--) begin
            sum_s     = int'(base_s) + i;
            cand_s    = (sum_s >= NPORT) ? PS_W'(sum_s - NPORT) : PS_W'(sum_s);
            gnt_idx   = req[cand_s] ? cand_s : gnt_idx;
            gnt_valid = gnt_valid | req[cand_s];
        end
    end

    // Pointer moves past the port that just finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {PS_W{1'b0}};
        end else if (advance) begin
            ptr_r <= (last_gnt == PS_W'(NPORT - 1)) ? {PS_W{1'b0}} : last_gnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/axi_line_ctl.sv
// AXI4 cache-line controller: arbitrates NPORT requesters onto one AXI master
// and moves whole lines through a shared line buffer. Arbitration policy is
// selected with AXI_LINE_CTL_RR_EN (round-robin) or left fixed-priority.
module axi_line_ctl
    import axi_line_pkg::*;
#(
    parameter  int NPORT      = 2,
    parameter  int ADDR_W     = 64,
    parameter  int DATA_W     = 64,
    parameter  int LINE_BEATS = 8,
    parameter  int ID         = 0,
    localparam int IDX_W      = clog2(LINE_BEATS),
    localparam int PS_W       = clog2(NPORT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wr,
    input  logic [NPORT*ADDR_W-1:0] addr,
    output logic [NPORT-1:0]        done,
    output logic                    err,
    output logic [PS_W-1:0]         gnt_id,
    input  logic [IDX_W-1:0]        buf_idx,
    input  logic [DATA_W-1:0]       buf_wdata,
    input  logic                    buf_wen,
    output logic [DATA_W-1:0]       buf_rdata,
    input  logic                    buf_commit,
    input  logic                    buf_release,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_W-1:0]       aw_addr,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [1:0]              aw_burst,
    output logic [ID_W-1:0]         aw_id,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_W-1:0]       w_data,
    output logic [DATA_W/8-1:0]     w_strb,
    output logic                    w_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [1:0]              b_resp,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ADDR_W-1:0]       ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    output logic [ID_W-1:0]         ar_id,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [DATA_W-1:0]       r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_last
);

    localparam int             CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LINE_BEATS - 1);

    line_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              err_r, err_nxt_s;
    logic [NPORT-1:0]  done_r, done_nxt_s;
    logic [PS_W-1:0]   gnt_r, arb_idx_s;
    logic              arb_valid_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] buf_r [LINE_BEATS];
    logic [DATA_W-1:0] w_data_r;
    logic              ar_valid_r, r_ready_r, aw_valid_r, w_valid_r, w_last_r, b_ready_r;
    logic              ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s, release_s, r_in_line_s;

    assign ar_hs_s     = ar_valid_r & ar_ready;
    assign r_hs_s      = r_ready_r & r_valid;
    assign aw_hs_s     = aw_valid_r & aw_ready;
    assign w_hs_s      = w_valid_r & w_ready;
    assign b_hs_s      = b_ready_r & b_valid;
    assign release_s   = (state_r == ST_DONE) & buf_release;
    assign r_in_line_s = (cnt_r < BEATS_C);

    axi_line_arb #(.NPORT(NPORT)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (release_s),
        .last_gnt  (gnt_r),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s)
    );

    // Next state, beat counter and sticky error.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
        done_nxt_s  = {NPORT{1'b0}};
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                err_nxt_s = 1'b0;
                if (arb_valid_s) state_nxt_s = wr[arb_idx_s] ? ST_FILL : ST_AR;
                else             state_nxt_s = ST_IDLE;
            end
            ST_AR:    state_nxt_s = ar_hs_s ? ST_RDATA : ST_AR;
            ST_RDATA: begin
                if (r_hs_s) begin
                    // Beats past the line end are dropped but flagged.
                    cnt_nxt_s   = r_in_line_s ? cnt_r + CNT_W'(1) : cnt_r;
                    err_nxt_s   = err_r | resp_is_err(r_resp) | ~r_in_line_s
                                | (r_last & (cnt_r != LAST_C));
                    state_nxt_s = r_last ? ST_DONE : ST_RDATA;
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
            ST_FILL:  state_nxt_s = buf_commit ? ST_AW : ST_FILL;
            ST_AW:    state_nxt_s = aw_hs_s ? ST_WDATA : ST_AW;
            ST_WDATA: begin
                if (w_hs_s) begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    state_nxt_s = w_last_r ? ST_BRESP : ST_WDATA;
                end else begin
                    state_nxt_s = ST_WDATA;
                end
            end
            ST_BRESP: begin
                if (b_hs_s) begin
                    err_nxt_s   = err_r | resp_is_err(b_resp);
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BRESP;
                end
            end
            ST_DONE: begin
                if (buf_release) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    err_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        for (int i = 0; i < NPORT; i++) begin
            done_nxt_s[i] = (state_nxt_s == ST_DONE) && (gnt_r == PS_W'(i));
        end
    end

    // State and all AXI/requester outputs registered from next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
            done_r     <= {NPORT{1'b0}};
            gnt_r      <= {PS_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            w_last_r   <= 1'b0;
            b_ready_r  <= 1'b0;
            w_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            err_r      <= err_nxt_s;
            done_r     <= done_nxt_s;
            ar_valid_r <= (state_nxt_s == ST_AR);
            r_ready_r  <= (state_nxt_s == ST_RDATA);
            aw_valid_r <= (state_nxt_s == ST_AW);
            w_valid_r  <= (state_nxt_s == ST_WDATA);
            b_ready_r  <= (state_nxt_s == ST_BRESP);
            w_last_r   <= (state_nxt_s == ST_WDATA) && (cnt_nxt_s == LAST_C);
            w_data_r   <= buf_r[cnt_nxt_s[IDX_W-1:0]];
            if ((state_r == ST_IDLE) && arb_valid_s) begin
                gnt_r  <= arb_idx_s;
                addr_r <= addr[arb_idx_s*ADDR_W +: ADDR_W];
            end
        end
    end

    // Line buffer: filled by R beats on reads, by the requester in FILL on writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINE_BEATS; i++) buf_r[i] <= {DATA_W{1'b0}};
        end else if ((state_r == ST_RDATA) && r_hs_s && r_in_line_s) begin
            buf_r[cnt_r[IDX_W-1:0]] <= r_data;
        end else if ((state_r == ST_FILL) && buf_wen) begin
            buf_r[buf_idx] <= buf_wdata;
        end
    end

    assign buf_rdata = buf_r[buf_idx];
    assign done      = done_r;
    assign err       = err_r;
    assign gnt_id    = gnt_r;
    assign ar_valid  = ar_valid_r;
    assign ar_addr   = addr_r;
    assign ar_len    = 8'(LINE_BEATS - 1);
    assign ar_size   = 3'(clog2(DATA_W / 8));
    assign ar_burst  = BURST_INCR;
    assign ar_id     = ID_W'(ID);
    assign r_ready   = r_ready_r;
    assign aw_valid  = aw_valid_r;
    assign aw_addr   = addr_r;
    assign aw_len    = 8'(LINE_BEATS - 1);
    assign aw_size   = 3'(clog2(DATA_W / 8));
    assign aw_burst  = BURST_INCR;
    assign aw_id     = ID_W'(ID);
    assign w_valid   = w_valid_r;
    assign w_data    = w_data_r;
    assign w_strb    = {(DATA_W/8){1'b1}};
    assign w_last    = w_last_r;
    assign b_ready   = b_ready_r;

endmodule
